// File: rtl/pipe_cla_adder16_pkg.sv
// Shared widths and the group generate/propagate type for the pipelined 16-bit CLA.
// Optional subtract support is enabled by defining CLA_SUB_EN.
package cla_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned GW    = 4;
    localparam int unsigned NGRP  = 4;

    typedef struct packed {
        logic [NGRP-1:0] g;
        logic [NGRP-1:0] p;
    } grp_gp_t;

    // Each group's G/P is built from bit-level g = a&b and p = a|b.
    function automatic grp_gp_t grp_gp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        grp_gp_t r;
        logic    gb;
        logic    pb;
        r = '0;
        for (int unsigned k = 0; k < NGRP; k++) begin
            r.g[k] = 1'b0;
            r.p[k] = 1'b1;
            for (int unsigned i = 0; i < GW; i++) begin
                gb     = a[k*GW+i] & b[k*GW+i];
                pb     = a[k*GW+i] | b[k*GW+i];
                r.g[k] = gb | (pb & r.g[k]);
                r.p[k] = r.p[k] & pb;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_cla_adder16_if.sv
// Operand/result handshake bundle for pipe_cla_adder16.
// The sub signal exists only when CLA_SUB_EN is defined.
interface pipe_cla_adder16_if;
    import cla_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef CLA_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`endif

endinterface

// File: rtl/pipe_cla_adder16_grp_carry_resolve.sv
// Flattened second-level lookahead: every group carry is a direct sum of products
// of the group G/P terms and cin, with no ripple between groups.
module grp_carry_resolve
    import cla_pkg::*;
(
    input  logic [NGRP-1:0] g_i,
    input  logic [NGRP-1:0] p_i,
    input  logic            cin_i,
    output logic [NGRP:0]   c_o
);

    logic term;
    logic prod;

    always_comb begin
        c_o    = '0;
        term   = 1'b0;
        prod   = 1'b0;
        c_o[0] = cin_i;
        for (int unsigned k = 0; k < NGRP; k++) begin
            // c[k+1] = G_k | P_k G_{k-1} | ... | P_k..P_0 cin
            prod = cin_i;
            for (int unsigned m = 0; m <= k; m++) begin
                prod = prod & p_i[m];
            end
            term = prod;
            for (int unsigned j = 0; j <= k; j++) begin
                prod = g_i[j];
                for (int unsigned m = j + 1; m <= k; m++) begin
                    prod = prod & p_i[m];
                end
                term = term | prod;
            end
            c_o[k+1] = term;
        end
    end

endmodule

// File: rtl/pipe_cla_adder16.sv
// Two-stage pipelined 16-bit carry-lookahead adder with valid/ready on both sides.
// Defining CLA_SUB_EN adds the sub input (a + ~b + 1).
module pipe_cla_adder16
    import cla_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    pipe_cla_adder16_if.slave   bus
);

    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    grp_gp_t          gp_q, gp_d;

    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic             s2_ld;
    logic             s1_adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [NGRP:0]    grp_c;
    logic [WIDTH-1:0] sum_w;
    logic             c15_w;

    assign s2_ld        = !s2_v_q || bus.out_ready;
    assign s1_adv       = !s1_v_q || s2_ld;
    assign bus.in_ready = s1_adv;

    assign bus.out_valid = s2_v_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

`ifdef CLA_SUB_EN
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    always_comb begin
        s1_v_d = s1_v_q;
        a_d    = a_q;
        b_d    = b_q;
        cin_d  = cin_q;
        gp_d   = gp_q;
        if (s1_adv) begin
            s1_v_d = bus.in_valid;
            if (bus.in_valid) begin
                a_d   = bus.a;
                b_d   = b_eff;
                cin_d = cin_eff;
                gp_d  = grp_gp(bus.a, b_eff);
            end
        end
    end

    grp_carry_resolve u_resolve (
        .g_i   (gp_q.g),
        .p_i   (gp_q.p),
        .cin_i (cin_q),
        .c_o   (grp_c)
    );

    // Bits inside a group use the resolved group carry; groups never chain.
    always_comb begin
        logic c;
        c     = 1'b0;
        c15_w = 1'b0;
        sum_w = '0;
        for (int unsigned k = 0; k < NGRP; k++) begin
            c = grp_c[k];
            for (int unsigned i = 0; i < GW; i++) begin
                sum_w[k*GW+i] = a_q[k*GW+i] ^ b_q[k*GW+i] ^ c;
                if (k*GW+i == WIDTH-1) begin
                    c15_w = c;
                end
                c = (a_q[k*GW+i] & b_q[k*GW+i]) | ((a_q[k*GW+i] | b_q[k*GW+i]) & c);
            end
        end
    end

    always_comb begin
        s2_v_d = s2_v_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        if (s2_ld) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                sum_d  = sum_w;
                cout_d = grp_c[NGRP];
                ovf_d  = c15_w ^ grp_c[NGRP];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            cin_q  <= 1'b0;
            gp_q   <= '0;
            s2_v_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            a_q    <= a_d;
            b_q    <= b_d;
            cin_q  <= cin_d;
            gp_q   <= gp_d;
            s2_v_q <= s2_v_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: tb/tb_pipe_cla_adder16.sv
// Self-checking bench for pipe_cla_adder16: directed corner cases, backpressure,
// reset mid-flight and a randomized stream against an arithmetic reference.
module tb_pipe_cla_adder16;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    pipe_cla_adder16_if bif ();

    pipe_cla_adder16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic; result packed as {ovf, cout, sum}.
    function automatic logic [17:0] ref_calc(input logic [15:0] x, input logic [15:0] y,
                                             input logic c, input logic s);
        logic [15:0] yy;
        int unsigned cc;
        int unsigned tot;
        int          sres;
        logic [17:0] r;
        yy   = s ? ~y : y;
        cc   = s ? 1 : int'(c);
        tot  = int'(x) + int'(yy) + cc;
        sres = int'($signed(x)) + int'($signed(yy)) + int'(cc);
        r[15:0] = tot[15:0];
        r[16]   = tot[16];
        r[17]   = (sres > 32767) || (sres < -32768);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic s, input logic ordy);
        @(negedge clk);
        bif.in_valid  = v;
        bif.a         = x;
        bif.b         = y;
        bif.cin       = c;
`ifdef CLA_SUB_EN
        bif.sub       = s;
`endif
        bif.out_ready = ordy;
        #1;
    endtask

    function automatic logic [17:0] observed();
        return {bif.ovf, bif.cout, bif.sum};
    endfunction

    // One isolated transaction: accept, nothing one cycle later, result the cycle after.
    task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                           input logic c, input logic s, input logic [17:0] exp);
        drive(1'b1, x, y, c, s, 1'b1);
        check({tag, "_accept"}, bif.in_ready, 1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        check({tag, "_lat1"}, bif.out_valid, 0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        check({tag, "_lat2"}, bif.out_valid, 1);
        check({tag, "_res"}, observed(), exp);
        check({tag, "_model"}, observed(), ref_calc(x, y, c, s));
    endtask

    logic [17:0] q[$];
    logic [17:0] exp_r;
    logic [17:0] held;
    logic        was_stalled;
    int          accepted;
    int          received;
    int          cyc;
    logic        rs;

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bif.in_valid  = 1'b0;
        bif.a         = '0;
        bif.b         = '0;
        bif.cin       = 1'b0;
`ifdef CLA_SUB_EN
        bif.sub       = 1'b0;
`endif
        bif.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", bif.out_valid, 0);
        check("rst_in_ready", bif.in_ready, 1);
        check("rst_result", observed(), 18'h0);

        run_one("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        run_one("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        run_one("neg_ovf", 16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});
        run_one("cin", 16'h1234, 16'h4321, 1'b1, 1'b0, {1'b0, 1'b0, 16'h5556});
        run_one("full_carry", 16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
`ifdef CLA_SUB_EN
        run_one("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
        run_one("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
`endif

        // Backpressure: third operand waits until the output drains.
        drive(1'b1, 16'd1, 16'd1, 1'b0, 1'b0, 1'b0);
        check("bp_acc1", bif.in_ready, 1);
        drive(1'b1, 16'd2, 16'd2, 1'b0, 1'b0, 1'b0);
        check("bp_acc2", bif.in_ready, 1);
        drive(1'b1, 16'd3, 16'd3, 1'b0, 1'b0, 1'b0);
        check("bp_full", bif.in_ready, 0);
        check("bp_hold_v", bif.out_valid, 1);
        check("bp_hold_sum", bif.sum, 16'h0002);
        drive(1'b1, 16'd3, 16'd3, 1'b0, 1'b0, 1'b0);
        check("bp_still_full", bif.in_ready, 0);
        check("bp_still_sum", bif.sum, 16'h0002);
        drive(1'b1, 16'd3, 16'd3, 1'b0, 1'b0, 1'b1);
        check("bp_free", bif.in_ready, 1);
        check("bp_out1", bif.sum, 16'h0002);
        drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        check("bp_out2_v", bif.out_valid, 1);
        check("bp_out2", bif.sum, 16'h0004);
        drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        check("bp_out3_v", bif.out_valid, 1);
        check("bp_out3", bif.sum, 16'h0006);
        drive(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        check("bp_empty", bif.out_valid, 0);

        // Randomized stream with random valid/ready.
        accepted    = 0;
        received    = 0;
        cyc         = 0;
        was_stalled = 1'b0;
        held        = '0;
        while ((accepted < 100 || q.size() > 0) && cyc < 3000) begin
            rs = 1'b0;
`ifdef CLA_SUB_EN
            rs = 1'($urandom_range(0, 1));
`endif
            drive((accepted < 100) ? 1'($urandom_range(0, 1)) : 1'b0,
                  16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), rs,
                  1'($urandom_range(0, 1)));
            if (was_stalled) begin
                check("stream_hold", observed(), held);
            end
            if (bif.out_valid && bif.out_ready) begin
                if (q.size() == 0) begin
                    check("stream_extra", 1, 0);
                end else begin
                    exp_r = q.pop_front();
                    check("stream_res", observed(), exp_r);
                    received++;
                end
            end
            was_stalled = bif.out_valid && !bif.out_ready;
            held        = observed();
            if (bif.in_valid && bif.in_ready) begin
                q.push_back(ref_calc(bif.a, bif.b, bif.cin, rs));
                accepted++;
            end
            cyc++;
        end
        check("stream_count", received, 100);
        check("stream_drained", q.size(), 0);

        // Reset with two transactions in flight.
        drive(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        check("mid_inflight", bif.out_valid, 1);
        check("mid_full", bif.in_ready, 0);
        #1 rst = 1'b1;
        #1;
        check("mid_async_clr", bif.out_valid, 0);
        check("mid_async_res", observed(), 18'h0);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            check("post_rst_quiet", bif.out_valid, 0);
            check("post_rst_ready", bif.in_ready, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
